// File: rtl/gpio_rgb_receiver.sv
// GPIO sink: captures R/G/B-tagged 32-bit words into three FIFOs and unpacks
// them into byte-wide RGB pixels on a valid/ready stream.
module gpio_rgb_receiver #(
  parameter int DEPTH     = 8,
  parameter int MAX_WORDS = 40000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      GPIO,
  input  logic             GPIOEnR,
  input  logic             GPIOEnG,
  input  logic             GPIOEnB,
  input  logic             GPIOEn,
  output logic [7:0]       pix_r,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_b,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [31:0]   mem_q    [3][DEPTH];
  logic [AW-1:0] wr_ptr_q [3];
  logic [AW-1:0] wr_ptr_d [3];
  logic [AW-1:0] rd_ptr_q [3];
  logic [AW-1:0] rd_ptr_d [3];
  logic [CW-1:0] cnt_q    [3];
  logic [CW-1:0] cnt_d    [3];
  logic [31:0]   head     [3];

  logic [2:0]       push_req, push_acc, full, empty;
  logic [1:0]       lane_q, lane_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             cap_en, done_set;
  logic             fire, pop, wc_last, all_empty;

  // ---------------------------------------------------------------------------
  // FIFO status and push arbitration
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      full[ch]  = (cnt_q[ch] == CW'(DEPTH));
      empty[ch] = (cnt_q[ch] == '0);
      head[ch]  = mem_q[ch][rd_ptr_q[ch]];
    end
  end

  assign push_req  = {GPIOEnB, GPIOEnG, GPIOEnR} & {3{cap_en}};
  assign pix_valid = ~|empty;
  assign fire      = pix_valid & pix_ready;
  assign pop       = fire & (lane_q == 2'd3);
  // A full FIFO still takes the word when the same edge frees its head slot.
  assign push_acc  = push_req & (~full | {3{pop}});
  assign all_empty = &empty;
  assign wc_last   = (wc_q == CNT_W'(MAX_WORDS - 1));

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      wr_ptr_d[ch] = push_acc[ch] ? wr_ptr_q[ch] + AW'(1) : wr_ptr_q[ch];
      rd_ptr_d[ch] = pop ? rd_ptr_q[ch] + AW'(1) : rd_ptr_q[ch];
      cnt_d[ch]    = cnt_q[ch] + CW'(push_acc[ch]) - CW'(pop);
    end
  end

  always_comb begin
    lane_d = fire ? lane_q + 2'd1 : lane_q;
    wc_d   = push_acc[2] ? wc_q + CNT_W'(1) : wc_q;
    ovf_d  = ovf_q | (|(push_req & full & ~{3{pop}}));
    done_d = done_set;
  end

  // ---------------------------------------------------------------------------
  // Storage: data words carry no reset, only pointers and counts do
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      if (push_acc[ch]) begin
        mem_q[ch][wr_ptr_q[ch]] <= GPIO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        cnt_q[ch]    <= '0;
      end
      lane_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      wc_q   <= '0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
      end
      lane_q <= lane_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      wc_q   <= wc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (GPIOEn) begin
          state_d = (push_acc[2] && wc_last) ? S_DRAIN : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (push_acc[2] && wc_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (all_empty && (lane_q == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    cap_en   = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      S_IDLE:    cap_en   = GPIOEn;
      S_CAPTURE: cap_en   = 1'b1;
      S_DRAIN:   cap_en   = 1'b0;
      S_DONE:    done_set = 1'b1;
      default:   cap_en   = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel output: lane selects the byte of each FIFO head
  always_comb begin
    pix_r = 8'h00;
    pix_g = 8'h00;
    pix_b = 8'h00;
    if (pix_valid) begin
      pix_r = head[0][{lane_q, 3'b000} +: 8];
      pix_g = head[1][{lane_q, 3'b000} +: 8];
      pix_b = head[2][{lane_q, 3'b000} +: 8];
    end
  end

  assign overflow   = ovf_q;
  assign done       = done_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_gpio_rgb_receiver.sv
// Directed bench for gpio_rgb_receiver: a vector table for the unpack and
// backpressure flows, plus hand sequences for overflow, termination and reset.
module tb_gpio_rgb_receiver;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio;
  logic        en, en_r, en_g, en_b, rdy;

  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_valid, a_ovf, a_done, b_valid, b_ovf, b_done;
  logic [15:0] a_wc, b_wc;

  int checks = 0;
  int errors = 0;

  // Small-MAX_WORDS instance for termination; large one for the full-FIFO case.
  gpio_rgb_receiver #(.DEPTH(8), .MAX_WORDS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst_n), .GPIO(gpio),
    .GPIOEnR(en_r), .GPIOEnG(en_g), .GPIOEnB(en_b), .GPIOEn(en),
    .pix_r(a_r), .pix_g(a_g), .pix_b(a_b), .pix_valid(a_valid),
    .pix_ready(rdy), .overflow(a_ovf), .done(a_done), .word_count(a_wc)
  );

  gpio_rgb_receiver #(.DEPTH(8), .MAX_WORDS(64), .CNT_W(16)) dut_big (
    .clk(clk), .rst(rst_n), .GPIO(gpio),
    .GPIOEnR(en_r), .GPIOEnG(en_g), .GPIOEnB(en_b), .GPIOEn(en),
    .pix_r(b_r), .pix_g(b_g), .pix_b(b_b), .pix_valid(b_valid),
    .pix_ready(rdy), .overflow(b_ovf), .done(b_done), .word_count(b_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] gpio;
    logic        en, er, eg, eb, rdy;
    logic        exp_v;
    logic [23:0] exp_pix;
    logic        exp_ovf;
    logic        exp_done;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t tbl [32];
  int   ntbl;

  function automatic vec_t mk(input logic rn, input logic [31:0] d,
                              input logic e, input logic r, input logic g,
                              input logic b, input logic rd, input logic v,
                              input logic [23:0] pix, input logic [15:0] wc);
    vec_t t;
    t.rst_n = rn; t.gpio = d; t.en = e; t.er = r; t.eg = g; t.eb = b;
    t.rdy = rd; t.exp_v = v; t.exp_pix = pix; t.exp_ovf = 1'b0;
    t.exp_done = 1'b0; t.exp_wc = wc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] d, input logic e, input logic r,
                      input logic g, input logic b, input logic rd);
    gpio = d; en = e; en_r = r; en_g = g; en_b = b; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; gpio = '0; en = 0; en_r = 0; en_g = 0; en_b = 0; rdy = 0;
    ntbl = 0;
    // reset, pre-arm ignore, basic unpack with ready held high
    tbl[ntbl++] = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'h11223344, 0, 1, 0, 0, 1, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'h44332211, 1, 1, 0, 0, 1, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'h88776655, 0, 0, 1, 0, 1, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'hCCBBAA99, 0, 0, 0, 1, 1, 1, 24'h115599, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h2266AA, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h3377BB, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h4488CC, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 0, 24'h000000, 1);
    // backpressure: five stalled cycles, then the rest in order
    tbl[ntbl++] = mk(0, 32'h0,        0, 0, 0, 0, 0, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'h44332211, 1, 1, 0, 0, 0, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'h88776655, 0, 0, 1, 0, 0, 0, 24'h000000, 0);
    tbl[ntbl++] = mk(1, 32'hCCBBAA99, 0, 0, 0, 1, 0, 1, 24'h115599, 1);
    for (int i = 0; i < 5; i++)
      tbl[ntbl++] = mk(1, 32'h0,      0, 0, 0, 0, 0, 1, 24'h115599, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h2266AA, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h3377BB, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 1, 24'h4488CC, 1);
    tbl[ntbl++] = mk(1, 32'h0,        0, 0, 0, 0, 1, 0, 24'h000000, 1);

    for (int i = 0; i < ntbl; i++) begin
      rst_n = tbl[i].rst_n;
      step(tbl[i].gpio, tbl[i].en, tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].rdy);
      chk($sformatf("row%0d_valid", i), 32'(a_valid), 32'(tbl[i].exp_v));
      chk($sformatf("row%0d_pix", i), {8'h0, a_r, a_g, a_b}, {8'h0, tbl[i].exp_pix});
      chk($sformatf("row%0d_ovf", i), 32'(a_ovf), 32'(tbl[i].exp_ovf));
      chk($sformatf("row%0d_done", i), 32'(a_done), 32'(tbl[i].exp_done));
      chk($sformatf("row%0d_wc", i), 32'(a_wc), 32'(tbl[i].exp_wc));
    end

    // Overflow: nine R words into an 8-deep FIFO
    rst_n = 1'b0; step(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      step(32'h44332211 + 32'h01010101 * i, (i == 0), 1, 0, 0, 0);
    chk("ovf_before_9th", 32'(a_ovf), 32'd0);
    step(32'hFFFFFFFF, 0, 1, 0, 0, 0);
    chk("ovf_after_9th", 32'(a_ovf), 32'd1);
    step(32'h88776655, 0, 0, 1, 0, 0);
    step(32'hCCBBAA99, 0, 0, 0, 1, 0);
    chk("ovf_head_valid", 32'(a_valid), 32'd1);
    chk("ovf_head_pix", {8'h0, a_r, a_g, a_b}, 32'h00115599);
    chk("ovf_sticky", 32'(a_ovf), 32'd1);

    // Reset mid-stream after the first pixel is accepted
    step(0, 0, 0, 0, 0, 1);
    chk("mid_pix1", {8'h0, a_r, a_g, a_b}, 32'h002266AA);
    rst_n = 1'b0; step(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_wc", 32'(a_wc), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_pix", {8'h0, a_r, a_g, a_b}, 32'd0);
    step(32'hDEADBEEF, 0, 1, 1, 1, 0);
    chk("rst_idle_ignore_valid", 32'(a_valid), 32'd0);
    chk("rst_idle_ignore_wc", 32'(a_wc), 32'd0);
    step(32'h0D0C0B0A, 1, 1, 1, 1, 0);
    chk("rearm_valid", 32'(a_valid), 32'd1);
    chk("rearm_pix", {8'h0, a_r, a_g, a_b}, 32'h000A0A0A);
    chk("rearm_wc", 32'(a_wc), 32'd1);

    // Full FIFOs: push accepted on the lane-3 pop edge
    rst_n = 1'b0; step(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      step(32'h01010101 * (k + 1), (k == 0), 1, 1, 1, 0);
    chk("full_wc", 32'(b_wc), 32'd8);
    chk("full_ovf", 32'(b_ovf), 32'd0);
    chk("full_pix_r", 32'(b_r), 32'h01);
    for (int l = 0; l < 3; l++) step(0, 0, 0, 0, 0, 1);
    step(32'h09090909, 0, 1, 1, 1, 1);
    chk("popush_ovf", 32'(b_ovf), 32'd0);
    chk("popush_wc", 32'(b_wc), 32'd9);
    for (int k = 1; k <= 8; k++) begin
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("drain_w%0d_l%0d", k, l), {7'h0, b_valid, b_r, b_g, b_b},
            {7'h0, 1'b1, 8'(k + 1), 8'(k + 1), 8'(k + 1)});
        step(0, 0, 0, 0, 0, 1);
      end
    end
    chk("drain_empty", 32'(b_valid), 32'd0);

    // Termination with MAX_WORDS=2
    rst_n = 1'b0; step(0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    for (int t = 0; t < 3; t++)
      step(32'h01010101 * (t + 1), (t == 0), 1, 1, 1, 0);
    chk("term_wc", 32'(a_wc), 32'd2);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("term_pix%0d", p), {7'h0, a_valid, a_r, a_g, a_b},
          {7'h0, 1'b1, 8'(p / 4 + 1), 8'(p / 4 + 1), 8'(p / 4 + 1)});
      step(0, 0, 0, 0, 0, 1);
    end
    chk("term_third_ignored", 32'(a_valid), 32'd0);
    for (int w = 0; w < 8 && !a_done; w++) step(32'h77777777, 1, 1, 1, 1, 1);
    chk("term_done", 32'(a_done), 32'd1);
    for (int w = 0; w < 3; w++) begin
      step(32'h55555555, 1, 1, 1, 1, 1);
      chk($sformatf("term_done_hold%0d", w), 32'(a_done), 32'd1);
      chk($sformatf("term_wc_hold%0d", w), 32'(a_wc), 32'd2);
      chk($sformatf("term_valid_hold%0d", w), 32'(a_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_rgb_receiver.md
Name: gpio_rgb_receiver

Overview:
- Sink end of the processor's GPIO output interface: captures 32-bit words tagged by the GPIOEnR, GPIOEnG and GPIOEnB strobes into three per-channel FIFOs.
- Unpacks the words into byte-wide RGB pixels and presents them on a valid/ready stream for downstream consumers (display or UART bridge).
- Arms on GPIOEn and terminates after a fixed number of B words.

Parameters:
- DEPTH, 8, entries per channel FIFO (32-bit words); power of two, ≥2.
- MAX_WORDS, 40000, number of B words accepted before capture stops.
- CNT_W, 16, width of word_count; must hold MAX_WORDS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on a clk edge).
- GPIO  in  32  data word from processor.
- GPIOEnR  in  1  GPIO carries a red word this cycle.
- GPIOEnG  in  1  GPIO carries a green word this cycle.
- GPIOEnB  in  1  GPIO carries a blue word this cycle.
- GPIOEn  in  1  processor output-start flag; arms capture.
- pix_r  out  8  red byte of current pixel.
- pix_g  out  8  green byte of current pixel.
- pix_b  out  8  blue byte of current pixel.
- pix_valid  out  1  pixel on pix_* is valid.
- pix_ready  in  1  consumer accepts the pixel.
- overflow  out  1  sticky; a word was dropped on a full FIFO.
- done  out  1  all MAX_WORDS B words captured and fully drained.
- word_count  out  CNT_W  B words accepted so far.

Behaviour:
- Reset (rst=0 at an edge):
  - State IDLE; FIFOs flushed; lane=0.
  - pix_valid, overflow and done clear to 0; word_count=0; pix_r, pix_g and pix_b are 0.
  - Reset mid-stream discards all buffered data.
- States:
  - IDLE: GPIOEn=1 → CAPTURE.
  - CAPTURE: the B push that makes word_count==MAX_WORDS → DRAIN.
  - DRAIN: all FIFOs empty and lane==0 → DONE.
  - DONE: held until reset.
- Capture enable: active when state is CAPTURE, or when state is IDLE and GPIOEn=1 in the same cycle. Strobes arriving in the same cycle as GPIOEn are therefore captured. All other strobes in IDLE, DRAIN and DONE are ignored and do not set overflow.
- Push: while capture is enabled, each asserted GPIOEnX pushes GPIO into FIFO X. Several strobes in one cycle push the same word into each selected FIFO.
- Full FIFO: the push is dropped and overflow is set (sticky).
  - Exception: if the same edge pops that FIFO (lane-3 handshake), the push is accepted.
- word_count increments on each accepted B push.
- Output:
  - pix_valid = all three FIFOs non-empty.
  - pix_r, pix_g and pix_b are the lane-selected bytes of the three FIFO heads: lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24].
  - pix_* read 0 when pix_valid=0.
  - Outputs are combinational from registered FIFO heads and lane. A word pushed at edge N becomes visible from cycle N+1.
- Handshake:
  - On pix_valid & pix_ready, lane increments.
  - At lane 3, all three FIFOs pop together and lane wraps to 0.
  - pix_ready=0 holds the pixel and lane stable; pix_ready while invalid has no effect.
- Throughput: one pixel per cycle; four pixels per RGB word triple.
- done: asserted the cycle after entering DONE; stays 1 until reset.

Test Plan:
- Pre-arm ignore: GPIOEnR=1 with GPIO=0x11223344 and GPIOEn=0 in IDLE → no push, pix_valid=0, overflow=0.
- Basic unpack:
  - Stimulus: GPIOEn=1 with R=0x44332211 in the same cycle, then G=0x88776655, then B=0xCCBBAA99; pix_ready=1 throughout.
  - Response: pix_valid rises the cycle after the B push. Pixels in order: (11,55,99), (22,66,AA), (33,77,BB), (44,88,CC), one per cycle. pix_valid then drops and word_count=1.
- Backpressure: as the basic unpack case, with pix_ready=0 for 5 cycles after valid → pix_*=(11,55,99) held stable. After ready=1 the remaining three pixels follow in order with none skipped.
- Overflow and simultaneous pop:
  - With DEPTH=8, pushing 9 R words and no G/B → overflow=1 after the 9th; the R head is still the first word.
  - Separately, with all FIFOs full, a push on the lane-3 accept edge is accepted and overflow stays 0.
- Termination: with MAX_WORDS=2, push 3 RGB triples → third B ignored, word_count=2. After 8 pixels are drained, done=1 and remains 1. Further strobes are ignored.
- Reset mid-stream: after the first of four pixels is accepted, drive rst=0 for one edge → pix_valid=0, word_count=0, done=0, overflow=0, state IDLE. Strobes are ignored until GPIOEn is seen again.
